// File: rtl/elastic_buffer_pkg.sv
// -----------------------------------------------------------------------------
// elastic_buffer_pkg
// Shared helpers for the elastic buffer slice:
//   ptr_width(depth)       : bits needed to index DEPTH storage entries
//   cnt_width(depth)       : bits needed to hold an occupancy of 0..DEPTH
//   ptr_inc(ptr, depth)    : pointer increment with explicit wrap at depth-1
// No ports (package).
// -----------------------------------------------------------------------------
package elastic_buffer_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap by compare rather than by letting the pointer overflow, so that
    // non-power-of-two depths index only valid entries.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/ebs_storage.sv
// -----------------------------------------------------------------------------
// ebs_storage
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port.
// Ports:
//   clk      : clock, all writes on posedge
//   clr      : synchronous clear of every entry (dominates write)
//   wr_en    : write enable
//   wr_ptr   : write index (0..DEPTH-1)
//   wr_data  : write payload
//   rd_ptr   : read index (0..DEPTH-1)
//   rd_data  : mem[rd_ptr], combinational from registered storage
// -----------------------------------------------------------------------------
module ebs_storage
    import elastic_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [ptr_width(DEPTH)-1:0]   wr_ptr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [ptr_width(DEPTH)-1:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clearing keeps the read port at zero whenever the buffer has just been
    // emptied by reset or flush, so downstream never sees stale payload there.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/elastic_buffer_slice.sv
// -----------------------------------------------------------------------------
// elastic_buffer_slice
// DEPTH-entry ready/valid elastic buffer. Both handshake outputs are
// registered, so it cuts every timing path between producer and consumer while
// sustaining one transfer per cycle.
//
// Handshake: a word moves on a rising edge where valid and ready are both high
// on that link. Upstream push = valid_in & ready_out; downstream
// pop = valid_out & ready_in. Upstream must hold data_in stable while
// valid_in is high and ready_out is low (not checked here).
//
// Optional feature macro: ELASTIC_BUFFER_OCCUPANCY_EN adds the occupancy and
// almost_full ports; without it those ports and the almost_full register do
// not exist and AF_LEVEL has no effect.
//
// Ports:
//   clk          : clock, all logic on posedge
//   reset        : synchronous active-high reset (highest priority)
//   flush        : synchronous discard of every stored entry
//   valid_in     : upstream data valid
//   data_in      : upstream payload
//   ready_in     : downstream ready
//   ready_out    : buffer can accept (registered)
//   valid_out    : buffer holds data (registered)
//   data_out     : oldest stored entry
//   occupancy    : entries held (optional)
//   almost_full  : occupancy >= AF_LEVEL, registered (optional)
// -----------------------------------------------------------------------------
module elastic_buffer_slice
    import elastic_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    ready_in,
    output logic                    ready_out,
    output logic                    valid_out,
    output logic [DATA_WIDTH-1:0]   data_out
`ifdef ELASTIC_BUFFER_OCCUPANCY_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] occupancy,
    output logic                        almost_full
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || DATA_WIDTH < 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_params
            $error("elastic_buffer_slice: illegal parameter combination");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign push = valid_in & ready_out;
    assign pop  = valid_out & ready_in;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Flags are computed from the next count and registered, so ready_out
    // never depends combinationally on ready_in. A pushed word is only
    // visible the cycle after it is written (no bypass).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
            end
            count     <= count_next;
            ready_out <= (count_next != DEPTH_C);
            valid_out <= (count_next != '0);
        end
    end

`ifdef ELASTIC_BUFFER_OCCUPANCY_EN
    localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_next >= AF_C);
        end
    end

    assign occupancy = count;
`endif

    // A push landing in the flush cycle is dropped (the clear dominates), yet
    // upstream still sees it as accepted because ready_out was high.
    ebs_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk     (clk),
        .clr     (reset | flush),
        .wr_en   (push),
        .wr_ptr  (wr_ptr),
        .wr_data (data_in),
        .rd_ptr  (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: doc/elastic_buffer_slice.md
Name: elastic_buffer_slice

Overview:
Parametrised ready/valid elastic buffer for cutting timing paths between producer and consumer. It generalises the two-entry full register slice to DEPTH entries, sustaining one transfer per cycle with registered ready_out and valid_out. It adds a synchronous flush and optional occupancy reporting, and sits between pipeline stages on any ready/valid link.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; any value, not restricted to powers of two)
AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (only used with the optional feature; 1..DEPTH)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all stored entries
valid_in  input  1  upstream data valid
data_in  input  DATA_WIDTH  upstream payload
ready_in  input  1  downstream ready
ready_out  output  1  buffer can accept (to upstream)
valid_out  output  1  buffer holds data (to downstream)
data_out  output  DATA_WIDTH  oldest stored entry
occupancy  output  $clog2(DEPTH+1)  entries held (optional feature only)
almost_full  output  1  occupancy >= AF_LEVEL (optional feature only)

Behaviour:
- Reset (sync, highest priority): pointers=0, count=0, ready_out=1, valid_out=0, data_out=0, occupancy=0, almost_full=0. Storage contents are don't-care but are zeroed in sim-visible form.
- Push = valid_in & ready_out. Pop = valid_out & ready_in.
- Storage is a circular array of DEPTH entries. wr_ptr and rd_ptr wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- count is held in a register. It changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
- ready_out and valid_out are registered, computed from next-state count: ready_out = (count_next != DEPTH), valid_out = (count_next != 0). There is no combinational path from ready_in to ready_out.
- data_out = mem[rd_ptr]. This is a mux of registered storage, with no input-to-output combinational path. data_out reads 0 when empty after reset/flush.
- Latency: a word accepted in cycle N is presentable at valid_out in cycle N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one word per cycle sustained in steady state with ready_in=1.
- Full (count=DEPTH): ready_out=0. Pop is still allowed, and ready_out rises the cycle after the pop.
- Empty (count=0): valid_out=0. A push when empty makes valid_out=1 next cycle.
- Simultaneous push and pop at count=1: both complete, count stays 1, data_out shows the new word next cycle.
- flush (sync, below reset): next cycle count=0, pointers=0, valid_out=0, ready_out=1. A push or pop in the flush cycle is discarded, and the upstream handshake is still considered completed.
- Ordering is strict FIFO. No word is duplicated or dropped except by flush or reset.
- Upstream must hold data_in stable while valid_in & ~ready_out. The block does not check this.

Optional Feature:
Macro ELASTIC_BUFFER_OCCUPANCY_EN.
- Defined: ports occupancy (registered count) and almost_full are present. almost_full is registered, equals (count_next >= AF_LEVEL), resets to 0, and clears on flush.
- Undefined: both ports and the almost_full register are absent. AF_LEVEL is ignored. Core behaviour is identical.

Decomposition:
- Shared package elastic_buffer_pkg holds the pointer increment-with-wrap function and the count-width function ($clog2(DEPTH+1)).
- One natural sub-module, ebs_storage: a DEPTH x DATA_WIDTH register array with write port (wr_en, wr_ptr, data) and async read by rd_ptr.
- Control (pointers, count, flags, flush) stays in the top module.

Test Plan:
- Reset then idle: after reset=1 for 2 cycles with valid_in=0 -> ready_out=1, valid_out=0, data_out=0, occupancy=0.
- Fill with DEPTH=4, ready_in=0, push 0x11,0x22,0x33,0x44 -> ready_out=0 the cycle after the 4th push, occupancy=4, almost_full=1 from occupancy 3. A 5th word 0x55 is not accepted.
- Drain: from full, ready_in=1 -> data_out 0x11,0x22,0x33,0x44 on consecutive cycles, ready_out=1 the cycle after the first pop, valid_out=0 after the last.
- Streaming: valid_in=1 and ready_in=1 continuous for 100 words of incrementing data -> 100 consecutive transfers in order, occupancy constant at 1 after the first cycle.
- Wrap and backpressure: random valid_in/ready_in (50%) for 1000 cycles with DEPTH=3 -> scoreboard ordering exact, pointers wrap correctly, no ready_out/ready_in combinational dependence.
- Flush mid-stream: with 2 entries held, assert flush with simultaneous push 0x99 and pop -> next cycle valid_out=0, occupancy=0, 0x99 never appears at data_out.
